// File: rtl/time_sync_rx_pkg.sv
// Shared packet-header constants and receiver types for the time-sync stream.
package time_sync_rx_pkg;

    // Header layout: {seqno, type, TTL}
    localparam int unsigned PKH_TYPE_WIDTH = 4;
    localparam int unsigned PKH_TTL_WIDTH  = 4;

    localparam logic [PKH_TYPE_WIDTH-1:0] PKTYPE_TIME     = 4'h1;
    localparam logic [PKH_TYPE_WIDTH-1:0] PKTYPE_MON      = 4'h2;
    localparam logic [PKH_TTL_WIDTH-1:0]  PKH_INITIAL_TTL = 4'h7;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_ACCEPT   = 2'd1,
        EV_CSUM_ERR = 2'd2,
        EV_LEN_ERR  = 2'd3
    } rx_event_e;

endpackage

// File: rtl/time_sync_rx_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/time_sync_rx.sv
// Time-sync packet receiver: parses, validates and publishes 64-bit time plus health status.
module time_sync_rx
    import time_sync_rx_pkg::*;
#(
    parameter int unsigned  AXI_WIDTH       = 16,
    parameter int unsigned  TIMESTAMP_WIDTH = 64,
    parameter int unsigned  TIMEOUT_CYCLES  = 125000000,
    parameter int unsigned  COUNT_WIDTH     = 16,
    parameter string        DEBUG           = "false",
    localparam int unsigned SEQ_W           = AXI_WIDTH - (PKH_TYPE_WIDTH + PKH_TTL_WIDTH)
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [AXI_WIDTH-1:0]       incomingTDATA,
    input  logic                       incomingTVALID,
    input  logic                       incomingTLAST,
    output logic [TIMESTAMP_WIDTH-1:0] timestamp,
    output logic                       timestampValid,
    output logic                       secondsMarkerToggle,
    output logic                       synced,
    output logic [SEQ_W-1:0]           lastSeqno,
    output logic [COUNT_WIDTH-1:0]     goodCount,
    output logic [COUNT_WIDTH-1:0]     checksumErrCount,
    output logic [COUNT_WIDTH-1:0]     lengthErrCount,
    output logic [COUNT_WIDTH-1:0]     seqGapCount
);

    localparam int unsigned PKT_WORDS = 6;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned HDR_LO_W  = PKH_TYPE_WIDTH + PKH_TTL_WIDTH;
    localparam int unsigned WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

    rx_state_e                state_q, state_d;
    rx_event_e                evt_c;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [AXI_WIDTH-1:0]     sum_q, sum_d;
    logic [TIMESTAMP_WIDTH-1:0] hold_q, hold_d;
    logic [SEQ_W-1:0]         seq_hdr_q, seq_hdr_d;

    logic [TIMESTAMP_WIDTH-1:0] timestamp_q;
    logic                     ts_valid_q;
    logic                     toggle_q;
    logic                     synced_q;
    logic [WD_W-1:0]          wd_q;
    logic [SEQ_W-1:0]         last_seq_q;
    logic                     seq_track_q;

    logic [PKH_TYPE_WIDTH-1:0] hdr_type_c;
    logic [SEQ_W-1:0]         hdr_seq_c;
    logic                     hdr_is_time_c;
    logic                     gap_c;

    assign hdr_type_c    = incomingTDATA[HDR_LO_W-1 -: PKH_TYPE_WIDTH];
    assign hdr_seq_c     = incomingTDATA[AXI_WIDTH-1 -: SEQ_W];
    assign hdr_is_time_c = (hdr_type_c == PKTYPE_TIME);

    // FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; advances only on valid beats
    always_comb begin
        state_d = state_q;
        if (incomingTVALID) begin
            case (state_q)
                ST_HEADER: begin
                    if (incomingTLAST)      state_d = ST_HEADER;
                    else if (hdr_is_time_c) state_d = ST_COLLECT;
                    else                    state_d = ST_DISCARD;
                end
                ST_COLLECT: begin
                    if (incomingTLAST)          state_d = ST_HEADER;
                    else if (idx_q == LAST_IDX) state_d = ST_DISCARD;
                end
                ST_DISCARD: begin
                    if (incomingTLAST) state_d = ST_HEADER;
                end
                default: state_d = ST_HEADER;
            endcase
        end
    end

    // FSM outputs: payload capture, running checksum and per-packet verdict
    always_comb begin
        idx_d     = idx_q;
        sum_d     = sum_q;
        hold_d    = hold_q;
        seq_hdr_d = seq_hdr_q;
        evt_c     = EV_NONE;
        if (incomingTVALID) begin
            case (state_q)
                ST_HEADER: begin
                    if (hdr_is_time_c) begin
                        idx_d     = IDX_W'(1);
                        sum_d     = incomingTDATA;
                        seq_hdr_d = hdr_seq_c;
                        if (incomingTLAST) evt_c = EV_LEN_ERR;
                    end
                end
                ST_COLLECT: begin
                    if (idx_q == LAST_IDX) begin
                        if (!incomingTLAST)              evt_c = EV_LEN_ERR;
                        else if (incomingTDATA == sum_q) evt_c = EV_ACCEPT;
                        else                             evt_c = EV_CSUM_ERR;
                    end else begin
                        hold_d = {hold_q[TIMESTAMP_WIDTH-AXI_WIDTH-1:0], incomingTDATA};
                        sum_d  = sum_q + incomingTDATA;
                        idx_d  = idx_q + IDX_W'(1);
                        if (incomingTLAST) evt_c = EV_LEN_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Packet collection registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            idx_q     <= '0;
            sum_q     <= '0;
            hold_q    <= '0;
            seq_hdr_q <= '0;
        end else begin
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            hold_q    <= hold_d;
            seq_hdr_q <= seq_hdr_d;
        end
    end

    // Published time, marker toggle and sync watchdog; acceptance outranks expiry
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timestamp_q <= '0;
            ts_valid_q  <= 1'b0;
            toggle_q    <= 1'b0;
            synced_q    <= 1'b0;
            wd_q        <= '0;
            last_seq_q  <= '0;
            seq_track_q <= 1'b0;
        end else begin
            ts_valid_q <= 1'b0;
            if (evt_c == EV_ACCEPT) begin
                timestamp_q <= hold_q;
                ts_valid_q  <= 1'b1;
                toggle_q    <= ~toggle_q;
                synced_q    <= 1'b1;
                wd_q        <= WD_W'(TIMEOUT_CYCLES);
                last_seq_q  <= seq_hdr_q;
                seq_track_q <= 1'b1;
            end else if (synced_q) begin
                wd_q <= wd_q - WD_W'(1);
                if (wd_q == WD_W'(1)) begin
                    synced_q    <= 1'b0;
                    seq_track_q <= 1'b0;
                end
            end
        end
    end

    assign gap_c = (evt_c == EV_ACCEPT) && seq_track_q && (seq_hdr_q != last_seq_q + SEQ_W'(1));

    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_good_cnt (
        .clk(clk), .resetN(resetN), .inc(evt_c == EV_ACCEPT), .count(goodCount)
    );
    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_csum_cnt (
        .clk(clk), .resetN(resetN), .inc(evt_c == EV_CSUM_ERR), .count(checksumErrCount)
    );
    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_len_cnt (
        .clk(clk), .resetN(resetN), .inc(evt_c == EV_LEN_ERR), .count(lengthErrCount)
    );
    sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_gap_cnt (
        .clk(clk), .resetN(resetN), .inc(gap_c), .count(seqGapCount)
    );

    // Optional observation copies of the stream for on-chip debug
    if (DEBUG == "true") begin : g_debug
        (* mark_debug = "true" *) logic [AXI_WIDTH-1:0] dbg_tdata;
        (* mark_debug = "true" *) logic                 dbg_tvalid;
        (* mark_debug = "true" *) logic                 dbg_tlast;
        assign dbg_tdata  = incomingTDATA;
        assign dbg_tvalid = incomingTVALID;
        assign dbg_tlast  = incomingTLAST;
    end

    assign timestamp           = timestamp_q;
    assign timestampValid      = ts_valid_q;
    assign secondsMarkerToggle = toggle_q;
    assign synced              = synced_q;
    assign lastSeqno           = last_seq_q;

endmodule

// File: tb/tb_time_sync_rx.sv
// Bench for time_sync_rx: packet-level reference model, per-cycle compare, directed + random traffic.
module tb_time_sync_rx;
    import time_sync_rx_pkg::*;

    localparam int unsigned AW   = 16;
    localparam int unsigned TSW  = 64;
    localparam int          TO   = 100;
    localparam int unsigned CW   = 4;
    localparam int unsigned SW   = 8;
    localparam int          CMAX = (1 << CW) - 1;

    localparam int E_NONE = 0;
    localparam int E_ACC  = 1;
    localparam int E_CSE  = 2;
    localparam int E_LEN  = 3;

    logic           clk    = 1'b0;
    logic           resetN = 1'b0;
    logic [AW-1:0]  incomingTDATA  = '0;
    logic           incomingTVALID = 1'b0;
    logic           incomingTLAST  = 1'b0;
    logic [TSW-1:0] timestamp;
    logic           timestampValid;
    logic           secondsMarkerToggle;
    logic           synced;
    logic [SW-1:0]  lastSeqno;
    logic [CW-1:0]  goodCount, checksumErrCount, lengthErrCount, seqGapCount;

    time_sync_rx #(
        .AXI_WIDTH(AW), .TIMESTAMP_WIDTH(TSW), .TIMEOUT_CYCLES(TO),
        .COUNT_WIDTH(CW), .DEBUG("false")
    ) dut (
        .clk(clk), .resetN(resetN),
        .incomingTDATA(incomingTDATA), .incomingTVALID(incomingTVALID), .incomingTLAST(incomingTLAST),
        .timestamp(timestamp), .timestampValid(timestampValid),
        .secondsMarkerToggle(secondsMarkerToggle), .synced(synced), .lastSeqno(lastSeqno),
        .goodCount(goodCount), .checksumErrCount(checksumErrCount),
        .lengthErrCount(lengthErrCount), .seqGapCount(seqGapCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-beat annotation from the packet builder: what this beat must cause
    int             beat_evt = E_NONE;
    logic [TSW-1:0] beat_ts  = '0;
    logic [SW-1:0]  beat_seq = '0;

    // Reference model state
    logic [TSW-1:0] m_ts = '0;
    bit             m_strobe = 1'b0;
    bit             m_tog = 1'b0;
    int             m_good = 0, m_cse = 0, m_len = 0, m_gap = 0;
    int             m_seq = 0;
    int             m_last_acc = -1;
    int             ecnt = 0;

    logic [AW-1:0]  pkt[$];
    int             next_seq = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: act on the annotated verdict of each consumed beat
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_ts = '0; m_strobe = 1'b0; m_tog = 1'b0;
            m_good = 0; m_cse = 0; m_len = 0; m_gap = 0;
            m_seq = 0; m_last_acc = -1;
        end else begin
            ecnt++;
            m_strobe = 1'b0;
            if (incomingTVALID) begin
                case (beat_evt)
                    E_ACC: begin
                        if (m_last_acc >= 0 && (ecnt - m_last_acc) <= TO &&
                            int'(beat_seq) != ((m_seq + 1) % 256)) begin
                            if (m_gap < CMAX) m_gap++;
                        end
                        m_ts = beat_ts; m_strobe = 1'b1; m_tog = ~m_tog;
                        if (m_good < CMAX) m_good++;
                        m_seq = int'(beat_seq);
                        m_last_acc = ecnt;
                    end
                    E_CSE: if (m_cse < CMAX) m_cse++;
                    E_LEN: if (m_len < CMAX) m_len++;
                    default: ;
                endcase
            end
        end
    end

    // Compare every cycle just after the active edge
    always @(posedge clk) begin
        #1;
        check("timestamp", timestamp, m_ts);
        check("timestampValid", 64'(timestampValid), 64'(m_strobe));
        check("toggle", 64'(secondsMarkerToggle), 64'(m_tog));
        check("synced", 64'(synced), 64'(m_last_acc >= 0 && (ecnt - m_last_acc) < TO));
        check("lastSeqno", 64'(lastSeqno), 64'(m_seq));
        check("goodCount", 64'(goodCount), 64'(m_good));
        check("checksumErrCount", 64'(checksumErrCount), 64'(m_cse));
        check("lengthErrCount", 64'(lengthErrCount), 64'(m_len));
        check("seqGapCount", 64'(seqGapCount), 64'(m_gap));
    end

    function automatic logic [AW-1:0] csum5();
        logic [AW-1:0] s = '0;
        for (int i = 0; i < 5; i++) s = s + pkt[i];
        return s;
    endfunction

    task automatic make_time(input logic [7:0] seq, input logic [31:0] secs, input logic [31:0] ticks,
                             input int len, input bit bad_csum);
        pkt.delete();
        pkt.push_back({seq, PKTYPE_TIME, PKH_INITIAL_TTL});
        pkt.push_back(secs[31:16]);
        pkt.push_back(secs[15:0]);
        pkt.push_back(ticks[31:16]);
        pkt.push_back(ticks[15:0]);
        pkt.push_back(csum5() + (bad_csum ? 16'd1 : 16'd0));
        while (pkt.size() > len) void'(pkt.pop_back());
        while (pkt.size() < len) pkt.push_back(16'($urandom));
    endtask

    task automatic make_other(input logic [3:0] typ, input int len);
        pkt.delete();
        pkt.push_back({8'($urandom), typ, PKH_INITIAL_TTL});
        for (int i = 1; i < len; i++) pkt.push_back(16'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            incomingTVALID = 1'b0;
            incomingTDATA  = 16'($urandom);
            incomingTLAST  = 1'($urandom);
            beat_evt       = E_NONE;
        end
    endtask

    // Drive the built packet; verdict beat and outcome follow from length, type and checksum
    task automatic send(input bit gaps, input bit tail_idle);
        int len = pkt.size();
        int evt = E_NONE;
        int evt_beat = -1;
        logic [TSW-1:0] ts = '0;
        if (pkt[0][7:4] == PKTYPE_TIME) begin
            if (len == 6) begin
                evt = (pkt[5] == csum5()) ? E_ACC : E_CSE;
                evt_beat = 5;
                ts = {pkt[1], pkt[2], pkt[3], pkt[4]};
            end else begin
                evt = E_LEN;
                evt_beat = (len < 6) ? len - 1 : 5;
            end
        end
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            @(negedge clk);
            incomingTVALID = 1'b1;
            incomingTDATA  = pkt[i];
            incomingTLAST  = (i == len - 1);
            beat_evt       = (i == evt_beat) ? evt : E_NONE;
            beat_ts        = ts;
            beat_seq       = pkt[0][15:8];
        end
        if (tail_idle) idle(1);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("reset timestamp", timestamp, 64'h0);
        check("reset goodCount", 64'(goodCount), 64'h0);
        check("reset synced", 64'(synced), 64'h0);
        resetN = 1'b1;
        idle(2);

        // Good packet seqno 5
        make_time(8'd5, 32'h12345678, 32'h0ABCDEF0, 6, 1'b0);
        check("pinned checksum", 64'(pkt[5]), 64'h576F);
        send(1'b0, 1'b1);
        check("t1 timestamp", timestamp, 64'h123456780ABCDEF0);
        check("t1 strobe", 64'(timestampValid), 64'h1);
        check("t1 toggle", 64'(secondsMarkerToggle), 64'h1);
        check("t1 goodCount", 64'(goodCount), 64'h1);
        check("t1 synced", 64'(synced), 64'h1);
        check("t1 lastSeqno", 64'(lastSeqno), 64'h5);
        @(posedge clk); #1;
        check("t1 strobe one cycle", 64'(timestampValid), 64'h0);

        // Bad checksum
        make_time(8'd6, 32'h12345678, 32'h0ABCDEF0, 6, 1'b1);
        send(1'b0, 1'b1);
        check("t2 csumErr", 64'(checksumErrCount), 64'h1);
        check("t2 timestamp kept", timestamp, 64'h123456780ABCDEF0);
        check("t2 toggle kept", 64'(secondsMarkerToggle), 64'h1);

        // Short packet, then good packet
        make_time(8'd6, 32'hDEADBEEF, 32'h0, 4, 1'b0);
        send(1'b0, 1'b0);
        make_time(8'd6, 32'h00000001, 32'h00000002, 6, 1'b0);
        send(1'b0, 1'b1);
        check("t3 lenErr", 64'(lengthErrCount), 64'h1);
        check("t3 good", 64'(goodCount), 64'h2);
        check("t3 timestamp", timestamp, 64'h0000000100000002);

        // Over-long packet
        make_time(8'd7, 32'h55555555, 32'h66666666, 7, 1'b0);
        send(1'b0, 1'b1);
        check("t3 long lenErr", 64'(lengthErrCount), 64'h2);
        check("t3 long ts kept", timestamp, 64'h0000000100000002);

        // Sequence gap and wrap
        make_time(8'd8, 32'h1, 32'h3, 6, 1'b0);
        send(1'b0, 1'b1);
        check("t4 gap after 6->8", 64'(seqGapCount), 64'h1);
        make_time(8'd255, 32'h1, 32'h4, 6, 1'b0);
        send(1'b0, 1'b1);
        make_time(8'd0, 32'h1, 32'h5, 6, 1'b0);
        send(1'b0, 1'b1);
        check("t4 no gap on wrap", 64'(seqGapCount), 64'h2);
        check("t4 lastSeqno", 64'(lastSeqno), 64'h0);

        // Non-time packet and idle gaps mid-packet
        make_other(PKTYPE_MON, 3);
        send(1'b1, 1'b1);
        check("t5 mon good", 64'(goodCount), 64'h5);
        check("t5 mon lenErr", 64'(lengthErrCount), 64'h2);
        check("t5 mon csumErr", 64'(checksumErrCount), 64'h1);
        make_time(8'd1, 32'h00ABCDEF, 32'h00000777, 6, 1'b0);
        send(1'b1, 1'b1);
        check("t5 good after gaps", 64'(goodCount), 64'h6);
        check("t5 ts", timestamp, 64'h00ABCDEF00000777);

        // Watchdog boundary
        make_time(8'd2, 32'h2, 32'h2, 6, 1'b0);
        send(1'b0, 1'b1);
        repeat (TO - 1) @(posedge clk);
        #1 check("t6 synced at limit-1", 64'(synced), 64'h1);
        @(posedge clk);
        #1 check("t6 synced dropped", 64'(synced), 64'h0);
        make_time(8'd50, 32'h3, 32'h3, 6, 1'b0);
        send(1'b0, 1'b1);
        check("t6 no gap after timeout", 64'(seqGapCount), 64'h2);
        check("t6 resynced", 64'(synced), 64'h1);
        check("t6 good", 64'(goodCount), 64'h8);

        // Reset mid-packet
        make_time(8'd9, 32'h9, 32'h9, 6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            incomingTVALID = 1'b1; incomingTDATA = pkt[i]; incomingTLAST = 1'b0;
            beat_evt = E_NONE;
        end
        @(negedge clk);
        incomingTVALID = 1'b0;
        resetN = 1'b0;
        #1;
        check("t6 rst timestamp", timestamp, 64'h0);
        check("t6 rst synced", 64'(synced), 64'h0);
        check("t6 rst good", 64'(goodCount), 64'h0);
        check("t6 rst toggle", 64'(secondsMarkerToggle), 64'h0);
        idle(2);
        resetN = 1'b1;
        idle(1);
        make_time(8'd77, 32'h7, 32'h7, 6, 1'b0);
        send(1'b0, 1'b1);
        check("t6 post-rst good", 64'(goodCount), 64'h1);
        check("t6 post-rst gap", 64'(seqGapCount), 64'h0);
        check("t6 post-rst seq", 64'(lastSeqno), 64'd77);
        next_seq = 78;

        // Randomised traffic
        for (int p = 0; p < 250; p++) begin
            int r = int'($urandom_range(0, 99));
            logic [7:0] sq;
            if ($urandom_range(0, 19) == 0) idle($urandom_range(TO - 10, TO + 10));
            sq = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(next_seq);
            if (r < 55) begin
                make_time(sq, $urandom, $urandom, 6, 1'b0);
                next_seq = (int'(sq) + 1) % 256;
            end else if (r < 65) begin
                make_time(sq, $urandom, $urandom, 6, 1'b1);
            end else if (r < 78) begin
                make_time(sq, $urandom, $urandom, $urandom_range(1, 5), 1'b0);
            end else if (r < 85) begin
                make_time(sq, $urandom, $urandom, $urandom_range(7, 9), 1'b0);
            end else begin
                logic [3:0] t;
                t = 4'($urandom);
                while (t == PKTYPE_TIME) t = 4'($urandom);
                make_other(t, $urandom_range(1, 8));
            end
            send($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
